// File: rtl/leaf_stream_unpacker_pkg.sv
// Shared packet layout for the BFT leaf receive path: field positions, the
// packet struct and a helper that pulls out the destination leaf/port.
package leaf_pkg;

  localparam int PACKET_BITS   = 49;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_MSB    = 47;
  localparam int LEAF_LSB    = 43;
  localparam int PORT_MSB    = 42;
  localparam int PORT_LSB    = 39;
  localparam int ADDR_MSB    = 38;
  localparam int ADDR_LSB    = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } packet_t;

  typedef struct packed {
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
  } dest_t;

  function automatic dest_t get_dest(input logic [PACKET_BITS-1:0] pkt);
    packet_t pk;
    dest_t   d;
    pk     = pkt;
    d.leaf = pk.leaf;
    d.port = pk.port;
    return d;
  endfunction

endpackage

// File: rtl/leaf_stream_unpacker_if.sv
// Bus between the BFT leaf input, this unpacker and the user kernel streams.
// vld/ack: a head is transferred on a cycle where vld[p] && ack[p]; ack while
// vld is low has no effect, and vld never waits on ack.
interface leaf_stream_unpacker_if
  import leaf_pkg::*;
#(
  parameter int NUM_IN_PORTS = 2
);

  logic [PACKET_BITS-1:0]               din_leaf_bft2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]              vld_interface2user;
  logic [NUM_IN_PORTS-1:0]              ack_user2interface;

  modport master (
    output din_leaf_bft2interface,
    output ack_user2interface,
    input  dout_leaf_interface2user,
    input  vld_interface2user
  );

  modport slave (
    input  din_leaf_bft2interface,
    input  ack_user2interface,
    output dout_leaf_interface2user,
    output vld_interface2user
  );

endinterface

// File: rtl/leaf_stream_unpacker_fifo.sv
// First-word-fall-through synchronous FIFO: dout shows the head while not
// empty and reads 0 when empty. A write while full succeeds only alongside a read.
module leaf_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_BITS:0]   CNT_ONE   = 1;
  localparam logic [DEPTH_BITS:0]   CNT_DEPTH = DEPTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_rd, do_wr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale words become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/leaf_stream_unpacker.sv
// BFT leaf receive stage: registers the incoming packet, keeps those addressed
// to this leaf, and queues payloads per user port behind FWFT FIFOs.
module leaf_stream_unpacker
  import leaf_pkg::*;
#(
  parameter logic [NUM_LEAF_BITS-1:0] LEAF_ID         = 5'd5,
  parameter int                       NUM_IN_PORTS    = 2,
  parameter int                       FIFO_DEPTH_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  leaf_stream_unpacker_if.slave bus,
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);

  logic [PACKET_BITS-1:0] din_q;
  dest_t                  dest;
  logic                   accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= '0;
    else       din_q <= bus.din_leaf_bft2interface;
  end

  assign dest   = get_dest(din_q);
  assign accept = din_q[VALID_BIT] && (dest.leaf == LEAF_ID) &&
                  (32'(dest.port) < NUM_IN_PORTS);

  logic [NUM_IN_PORTS-1:0] fifo_full, fifo_empty, fifo_wr, pop, drop_hit;
  logic [PAYLOAD_BITS-1:0] head [NUM_IN_PORTS];

  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_port
    logic hit;
    assign hit         = accept && (32'(dest.port) == p);
    assign pop[p]      = bus.ack_user2interface[p] && !fifo_empty[p];
    // A full FIFO can still take the packet when its head leaves this cycle.
    assign fifo_wr[p]  = hit && (!fifo_full[p] || pop[p]);
    assign drop_hit[p] = hit && fifo_full[p] && !pop[p];

    leaf_sync_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (fifo_wr[p]),
      .din   (din_q[PAYLOAD_MSB:PAYLOAD_LSB]),
      .full  (fifo_full[p]),
      .rd_en (pop[p]),
      .dout  (head[p]),
      .empty (fifo_empty[p])
    );
  end

  always_comb begin
    bus.dout_leaf_interface2user = '0;
    for (int p = 0; p < NUM_IN_PORTS; p++) begin
      bus.dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = head[p];
    end
  end

  assign bus.vld_interface2user = ~fifo_empty;

  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = |drop_hit;

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/leaf_stream_unpacker.md
Name: leaf_stream_unpacker

Overview:
Receive-side stage of a BFT leaf. It takes 49-bit packets arriving from the BFT switch (din_leaf_bft2interface) and filters them by destination leaf. It demultiplexes each accepted packet by port into per-port FIFOs, then presents 32-bit payloads to the user kernel over a vld/ack handshake. It sits directly between the BFT leaf input and the user kernel's Input_N streams.

Parameters:
- PACKET_BITS, 49, total packet width
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, address field width (carried, ignored by this block)
- LEAF_ID, 5, this leaf's address; packets for other leaves are ignored
- NUM_IN_PORTS, 2, number of user input streams (1..8)
- FIFO_DEPTH_BITS, 4, per-port FIFO depth = 2^FIFO_DEPTH_BITS (16)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- din_leaf_bft2interface  in  PACKET_BITS  packet from BFT
- dout_leaf_interface2user  out  NUM_IN_PORTS*PAYLOAD_BITS  head payload per port; port p occupies bits [p*32 +: 32]
- vld_interface2user  out  NUM_IN_PORTS  head valid per port
- ack_user2interface  in  NUM_IN_PORTS  user consumes head per port
- overflow  out  1  sticky: a packet was dropped on a full FIFO
- drop_cnt  out  16  saturating count of overflow drops

Behaviour:
- Packet layout:
  - [48] valid
  - [47:43] dest leaf
  - [42:39] dest port
  - [38:32] addr
  - [31:0] payload
- Accept rule, evaluated each cycle: valid==1 && leaf==LEAF_ID && port<NUM_IN_PORTS.
  - Bad leaf or out-of-range port: packet silently discarded; no counter changes.
- Input register stage: din is registered once; the accept decision and FIFO write use the registered copy.
- Latency: packet present on din in cycle N is written at the end of cycle N+1. vld for that port is high in cycle N+2 if the FIFO was empty.
- FIFO is first-word-fall-through: dout shows the head whenever vld=1. dout content while vld=0 is don't-care but must not be X after reset.
- Handshake:
  - vld[p] = FIFO[p] non-empty.
  - A pop occurs in a cycle where vld[p]&&ack[p]; the next entry, if any, is on dout the following cycle.
  - ack while vld=0 is ignored.
- Full FIFO:
  - A write to a full FIFO is accepted if a pop happens on the same port in the same cycle; count is unchanged.
  - Otherwise the packet is dropped, overflow is set, and drop_cnt increments, saturating at 16'hFFFF.
- Empty FIFO with simultaneous write and pop: impossible, since vld=0; the write is performed normally.
- Pointers wrap modulo depth; count is tracked in FIFO_DEPTH_BITS+1 bits.
- Reset, asynchronous, including mid-stream:
  - Input register, all pointers and counts, overflow, and drop_cnt go to 0.
  - vld=0; dout=0.
  - Buffered data is discarded.
- overflow and drop_cnt clear only on reset.

Decomposition:
- Shared package leaf_pkg:
  - Field-position constants: VALID_BIT=48, LEAF_MSB/LSB, PORT_MSB/LSB, ADDR_MSB/LSB, PAYLOAD_MSB/LSB.
  - Packet struct or typedef for the 49-bit packet.
  - Function extracting the dest leaf/port.
- One sub-module: leaf_sync_fifo.
  - Parameterized width and depth; FWFT; ports wr_en/din/full, rd_en/dout/empty.
  - Same clk/reset; instantiated NUM_IN_PORTS times by a generate loop.

Test Plan:
- Reset, then a single packet {1,5'd5,4'd0,7'd0,32'hDEADBEEF} in cycle 0 -> vld[0]=1 in cycle 2 with dout[31:0]=DEADBEEF; ack in cycle 2 -> vld[0]=0 in cycle 3.
- Packets to port 0 (A1,A2) and port 1 (B1), interleaved -> each port delivers its data in order; no cross-talk between ports.
- Misaddressed traffic: leaf=6, port=4 (NUM_IN_PORTS=2), valid=0 -> no vld on any port, drop_cnt=0, overflow=0.
- Overflow: 17 packets to port 0 with ack held low -> 16 buffered, overflow=1, drop_cnt=1. A 17th write while acking in the same cycle -> accepted, drop_cnt stays 1.
- Wrap-around: 40 packets with values 0..39 and the user acking every other cycle -> all 40 received in order, no drops.
- Async reset asserted mid-stream with 5 entries buffered -> vld=0 immediately without waiting for a clock edge. After release, the old data is gone and a new packet arrives with standard latency.
